// File: rtl/text_pkg.sv
// Shared constants and types for the text overlay reader.
package text_pkg;
  localparam int CHAR_W       = 8;
  localparam int CHAR_H       = 16;
  localparam int CHAR_XY_W    = 12;
  localparam int CHAR_CODE_W  = 7;
  localparam int CHAR_LINE_W  = 11;
  localparam int TEXT_LATENCY = 4;

  typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} blink_state_t;
endpackage

// File: rtl/signal_delay.sv
// Fixed-depth register delay line with asynchronous active-low clear.
module signal_delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [CLK_DEL-1:0][WIDTH-1:0] taps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[CLK_DEL-1];
endmodule

// File: rtl/draw_text_reader.sv
// Text overlay: addresses the char ROM from the VGA stream, builds the font line
// address and paints set glyph pixels inside a fixed rectangle, with optional blink.
module draw_text_reader
  import text_pkg::*;
#(
  parameter int          XPOS         = 100,
  parameter int          YPOS         = 50,
  parameter int          COLS         = 32,
  parameter int          ROWS         = 1,
  parameter logic [11:0] TEXT_COLOR   = 12'hFFF,
  parameter int          BLINK_FRAMES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [10:0]            hcount_in,
  input  logic [10:0]            vcount_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   hblnk_in,
  input  logic                   vblnk_in,
  input  logic [11:0]            rgb_in,
  output logic [CHAR_XY_W-1:0]   char_xy,
  input  logic [CHAR_CODE_W-1:0] char_code,
  output logic [CHAR_LINE_W-1:0] char_line,
  input  logic [7:0]             char_pixels,
  output logic [10:0]            hcount_out,
  output logic [10:0]            vcount_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   hblnk_out,
  output logic                   vblnk_out,
  output logic [11:0]            rgb_out
);
  localparam logic [10:0] X0 = 11'(XPOS);
  localparam logic [10:0] Y0 = 11'(YPOS);
  localparam logic [10:0] XW = 11'(COLS * CHAR_W);
  localparam logic [10:0] YH = 11'(ROWS * CHAR_H);
  localparam int          BW = 1 + 3 + 1 + 12 + 4 + 22;

  logic [10:0]          xo, yo;
  logic                 in_rect;
  logic [CHAR_XY_W-1:0] idx;

  assign xo = hcount_in - X0;
  assign yo = vcount_in - Y0;
  // Range check first so negative offsets never wrap into the rectangle.
  assign in_rect = (hcount_in >= X0) && (xo < XW) && (vcount_in >= Y0) && (yo < YH);
  assign idx = CHAR_XY_W'(yo[10:4]) * CHAR_XY_W'(COLS) + CHAR_XY_W'(xo[10:3]);

  logic [1:0] vld_pipe;
  logic       frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy     <= '0;
      vld_pipe    <= '0;
      frame_start <= 1'b0;
    end else begin
      char_xy     <= in_rect ? idx : '0;
      vld_pipe    <= {vld_pipe[0], 1'b1};
      frame_start <= (hcount_in == 11'd0) && (vcount_in == 11'd0);
    end
  end

  // Stream bundle delayed to line up with char_pixels.
  logic [BW-1:0] bnd_d3;
  logic          en_d3, in_rect_d3, hs_d3, vs_d3, hb_d3, vb_d3;
  logic [2:0]    xo_d3;
  logic [11:0]   rgb_d3;
  logic [10:0]   hc_d3, vc_d3;
  logic [3:0]    row_d2;

  signal_delay #(.WIDTH(BW), .CLK_DEL(TEXT_LATENCY-1)) u_stream_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({en, xo[2:0], in_rect, rgb_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
            hcount_in, vcount_in}),
    .dout (bnd_d3)
  );
  assign {en_d3, xo_d3, in_rect_d3, rgb_d3, hs_d3, vs_d3, hb_d3, vb_d3, hc_d3, vc_d3} = bnd_d3;

  // Row must arrive alongside char_code, which the ROM returns a cycle after char_xy.
  signal_delay #(.WIDTH(4), .CLK_DEL(2)) u_row_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (yo[3:0]),
    .dout (row_d2)
  );

  assign char_line = vld_pipe[1] ? {char_code, row_d2} : '0;

  blink_state_t state, state_nxt;
  logic [15:0]  cnt, cnt_nxt;
  logic         visible;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SHOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!en || BLINK_FRAMES == 0) begin
      state_nxt = SHOW;
      cnt_nxt   = '0;
    end else if (frame_start) begin
      if (cnt == 16'(BLINK_FRAMES - 1)) begin
        cnt_nxt   = '0;
        state_nxt = (state == SHOW) ? HIDE : SHOW;
      end else begin
        cnt_nxt = cnt + 16'd1;
      end
    end
  end

  assign visible = (state == SHOW);

  logic pix_bit;
  assign pix_bit = char_pixels[3'd7 - xo_d3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hc_d3;
      vcount_out <= vc_d3;
      hsync_out  <= hs_d3;
      vsync_out  <= vs_d3;
      hblnk_out  <= hb_d3;
      vblnk_out  <= vb_d3;
      rgb_out    <= (in_rect_d3 && pix_bit && en_d3 && visible && !hb_d3 && !vb_d3)
                    ? TEXT_COLOR : rgb_d3;
    end
  end
endmodule

// File: tb/tb_draw_text_reader.sv
// Directed + random bench for draw_text_reader with behavioural ROMs and a scoreboard.
module tb_draw_text_reader;
  localparam int          XP = 100, YP = 50, NC = 32, NR = 2, BF = 2;
  localparam logic [11:0] TC = 12'hFFF;
  localparam int          MAXC = 8192;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 0;
  logic [11:0] rgb_in = '0;
  logic [11:0] char_xy;
  logic [6:0]  char_code;
  logic [10:0] char_line;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_text_reader #(.XPOS(XP), .YPOS(YP), .COLS(NC), .ROWS(NR), .TEXT_COLOR(TC),
                     .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_xy(char_xy), .char_code(char_code), .char_line(char_line),
    .char_pixels(char_pixels), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out),
    .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Behavioural char and font ROMs, one-cycle registered read each.
  logic [6:0] cmem [0:4095];
  logic [7:0] fmem [0:2047];
  always @(posedge clk) begin
    char_code   <= cmem[char_xy];
    char_pixels <= fmem[char_line];
  end

  typedef struct {
    logic        zero;
    logic [11:0] xy;
    logic [10:0] line;
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } ent_t;
  ent_t hist [0:MAXC-1];

  int   n_chk = 0, n_err = 0, t = 0, k = 0;
  logic en_s = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  // Present one pixel, record what the spec says must come out, then check matured entries.
  task automatic cyc(input int h, input int v, input logic hb, input logic vb,
                     input logic e, input logic r);
    int xo, yo, xl, yl, idx;
    logic inr, b, vis;
    logic [6:0] code;
    logic [7:0] pix;
    logic [11:0] rgb;
    ent_t ex;
    rgb = 12'($urandom);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    hblnk_in = hb; vblnk_in = vb; rgb_in = rgb; en = e;
    if (rst_n && !r) begin
      rst_n = 1'b0;
      #1;
      chk("async_xy", char_xy, 0);
      chk("async_line", char_line, 0);
      chk("async_rgb", rgb_out, 0);
      chk("async_h", hcount_out, 0);
      chk("async_v", vcount_out, 0);
      chk("async_sync", {hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
      for (int i = 1; i <= 4; i++) if (t - i >= 0) hist[t-i].zero = 1'b1;
    end else begin
      rst_n = r;
    end
    if (!r || !e) k = 0;
    xo = h - XP; yo = v - YP;
    inr = (xo >= 0) && (xo < NC*8) && (yo >= 0) && (yo < NR*16);
    idx = inr ? (yo / 16) * NC + xo / 8 : 0;
    code = cmem[idx];
    yl = ((yo % 16) + 16) % 16;
    xl = ((xo % 8) + 8) % 8;
    pix = fmem[{code, 4'(yl)}];
    b = pix[7 - xl];
    vis = (BF == 0) || ((k / BF) % 2 == 0);
    ex.zero = !r;
    ex.xy = 12'(idx);
    ex.line = {code, 4'(yl)};
    ex.h = 11'(h); ex.v = 11'(v);
    ex.hs = hsync_in; ex.vs = vsync_in; ex.hb = hb; ex.vb = vb;
    ex.rgb = (inr && b && e && vis && !hb && !vb) ? TC : rgb;
    hist[t] = ex;
    if (e && r && h == 0 && v == 0) k++;
    @(negedge clk);
    if (t >= 1) chk("char_xy", char_xy, hist[t-1].zero ? 0 : hist[t-1].xy);
    if (t >= 2) chk("char_line", char_line, hist[t-2].zero ? 0 : hist[t-2].line);
    if (t >= 4) begin
      ex = hist[t-4];
      chk("rgb_out", rgb_out, ex.zero ? 0 : ex.rgb);
      chk("hcount_out", hcount_out, ex.zero ? 0 : ex.h);
      chk("vcount_out", vcount_out, ex.zero ? 0 : ex.v);
      chk("timing_out", {hsync_out, vsync_out, hblnk_out, vblnk_out},
          ex.zero ? 0 : {ex.hs, ex.vs, ex.hb, ex.vb});
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(5, 5, 0, 0, en_s, 1);
  endtask

  task automatic frame_start();
    idle(4); cyc(0, 0, 0, 0, en_s, 1); idle(4);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) cmem[i] = 7'($urandom);
    for (int i = 0; i < 2048; i++) fmem[i] = 8'($urandom);
    cmem[0] = 7'h54;  fmem[11'h540] = 8'h80;
    cmem[31] = 7'h41; fmem[11'h410] = 8'hFF;

    @(posedge clk); #1;
    repeat (3) cyc($urandom_range(90, 370), $urandom_range(40, 90), 0, 0, 1, 0);
    idle(5);
    // Left edge, first glyph, index/row and rectangle boundaries.
    cyc(99, 50, 0, 0, 1, 1);  cyc(100, 50, 0, 0, 1, 1); cyc(101, 50, 0, 0, 1, 1);
    cyc(108, 53, 0, 0, 1, 1); cyc(100, 66, 0, 0, 1, 1);
    cyc(355, 50, 0, 0, 1, 1); cyc(356, 50, 0, 0, 1, 1);
    cyc(100, 81, 0, 0, 1, 1); cyc(100, 82, 0, 0, 1, 1); cyc(100, 49, 0, 0, 1, 1);
    cyc(100, 50, 1, 0, 1, 1); cyc(100, 50, 0, 1, 1, 1); cyc(100, 50, 0, 0, 0, 1);
    idle(4);
    // Blink: two frames shown, two hidden, en drop restarts shown.
    for (int f = 1; f <= 3; f++) begin frame_start(); cyc(100, 50, 0, 0, 1, 1); end
    idle(2); en_s = 1'b0; idle(4); cyc(100, 50, 0, 0, 0, 1);
    en_s = 1'b1; idle(4); cyc(100, 50, 0, 0, 1, 1);
    for (int f = 4; f <= 6; f++) begin frame_start(); cyc(100, 50, 0, 0, 1, 1); end
    idle(4);
    for (int i = 0; i < 1500; i++) begin
      int sel;
      sel = $urandom_range(0, 199);
      if (sel == 0) frame_start();
      else if (sel == 1) begin idle(4); en_s = !en_s; idle(4); end
      else cyc($urandom_range(90, 370), $urandom_range(40, 90),
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, en_s, 1);
    end
    // Reset in the middle of a line.
    en_s = 1'b1; idle(4);
    cyc(150, 55, 0, 0, 1, 1); cyc(158, 55, 0, 0, 1, 1);
    cyc(166, 55, 0, 0, 1, 0); cyc(174, 55, 0, 0, 1, 0);
    cyc(5, 5, 0, 0, 1, 1);
    for (int i = 0; i < 40; i++)
      cyc($urandom_range(90, 370), $urandom_range(45, 85), 0, 0, 1, 1);
    idle(6);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
